// File: rtl/if_stage_if.sv
// Fetch-stage bus: ROM port, pipeline control inputs and the IF/ID register outputs.
// master = fetch stage side, slave = ROM/decode/control side.
interface if_stage_if;
    logic [19:0] rom_addr;
    logic [31:0] rom_inst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        halted;
    logic        fault;
    logic        misalign;

    modport master (
        output rom_addr, id_pc, id_inst, id_valid, halted, fault, misalign,
        input  rom_inst, stall, redirect, redirect_pc
    );

    modport slave (
        input  rom_addr, id_pc, id_inst, id_valid, halted, fault, misalign,
        output rom_inst, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, combinational ROM access, IF/ID register, RUN/HALT/FAULT control.
// Optional macro IF_MISALIGN_CHECK_EN turns a misaligned redirect into a sticky fault.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 2049
) (
    input logic      clk,
    input logic      rst,
    if_stage_if.master bus
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ADDR_W    = 20;
    localparam logic [XLEN-1:0] NOP_INST    = 32'h0000_0013;
    localparam logic [XLEN-1:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] id_pc_q, id_pc_n;
    logic [XLEN-1:0] id_inst_q, id_inst_n;
    logic            id_valid_q, id_valid_n;
    logic            halted_c, fault_c;
    logic            in_range_c;
    logic            is_ebreak_c;
    logic            mis_redirect_c;

    assign in_range_c  = ({2'b00, pc_q[XLEN-1:2]} < XLEN'(ROM_WORDS));
    assign is_ebreak_c = (bus.rom_inst == EBREAK_INST);

`ifdef IF_MISALIGN_CHECK_EN
    assign mis_redirect_c = (bus.redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lsbs;
    assign mis_redirect_c       = 1'b0;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_n;
    end

    // Next state: redirect > stall > out-of-range > fetch; HALT/FAULT only leave on reset
    always_comb begin
        state_n = state_q;
        if (state_q == RUN) begin
            if (bus.redirect) begin
                if (mis_redirect_c) state_n = FAULT;
            end else if (!bus.stall) begin
                if (!in_range_c)      state_n = FAULT;
                else if (is_ebreak_c) state_n = HALT;
            end
        end
    end

    // State decode outputs
    always_comb begin
        halted_c = 1'b0;
        fault_c  = 1'b0;
        case (state_q)
            HALT:    halted_c = 1'b1;
            FAULT:   fault_c  = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        pc_n       = pc_q;
        id_pc_n    = id_pc_q;
        id_inst_n  = id_inst_q;
        id_valid_n = id_valid_q;
        if (state_q == RUN) begin
            if (bus.redirect) begin
                id_valid_n = 1'b0;
                if (!mis_redirect_c) pc_n = {bus.redirect_pc[XLEN-1:2], 2'b00};
            end else if (!bus.stall) begin
                if (!in_range_c) begin
                    id_valid_n = 1'b0;
                end else begin
                    id_inst_n  = bus.rom_inst;
                    id_pc_n    = pc_q;
                    id_valid_n = 1'b1;
                    pc_n       = pc_q + XLEN'(4);
                end
            end
        end else if (!bus.stall) begin
            id_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_n;
            id_pc_q    <= id_pc_n;
            id_inst_q  <= id_inst_n;
            id_valid_q <= id_valid_n;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q;

    // Sticky cause flag, only cleared by reset
    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (state_q == RUN && bus.redirect && mis_redirect_c)
            misalign_q <= 1'b1;
    end

    assign bus.misalign = misalign_q;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.rom_addr = pc_q[ADDR_W+1:2];
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign bus.id_valid = id_valid_q;
    assign bus.halted   = halted_c;
    assign bus.fault    = fault_c;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: default-size instance plus a ROM_WORDS=4 instance for the range fault.
module tb_if_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    if_stage_if bus();
    if_stage_if bus4();

    if_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .ROM_WORDS (4)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_rd(input logic [19:0] a);
        case (a)
            20'd0:   rom_rd = 32'h0000_0013;
            20'd1:   rom_rd = 32'h0000_0093;
            20'd2:   rom_rd = 32'h0000_0113;
            20'd3:   rom_rd = 32'h0010_0073;
            20'd16:  rom_rd = 32'h0050_0213;
            20'd17:  rom_rd = 32'h0060_0293;
            default: rom_rd = 32'h0000_0013;
        endcase
    endfunction

    assign bus.rom_inst  = rom_rd(bus.rom_addr);
    assign bus4.rom_inst = {bus4.rom_addr[11:0], 20'h00013};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0123;
        bus4.stall = 1'b0;
        bus4.redirect = 1'b0;
        bus4.redirect_pc = 32'h0;

        // Reset overrides stall and redirect
        tick();
        tick();
        check("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst_id_inst", bus.id_inst, 32'h0000_0013);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_misalign", 32'(bus.misalign), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);

        rst = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;

        tick();
        check("f0_id_pc", bus.id_pc, 32'h0);
        check("f0_id_inst", bus.id_inst, 32'h0000_0013);
        check("f0_id_valid", 32'(bus.id_valid), 32'd1);
        tick();
        check("f1_id_pc", bus.id_pc, 32'h4);
        check("f1_id_inst", bus.id_inst, 32'h0000_0093);
        check("f1_rom_addr", 32'(bus.rom_addr), 32'd2);

        bus.stall = 1'b1;
        tick();
        check("st1_id_pc", bus.id_pc, 32'h4);
        check("st1_rom_addr", 32'(bus.rom_addr), 32'd2);
        tick();
        check("st2_id_pc", bus.id_pc, 32'h4);
        check("st2_rom_addr", 32'(bus.rom_addr), 32'd2);
        check("st2_id_valid", 32'(bus.id_valid), 32'd1);
        check("r4_id_pc", bus4.id_pc, 32'hC);
        check("r4_fault_early", 32'(bus4.fault), 32'd0);

        bus.stall = 1'b0;
        tick();
        check("f2_id_pc", bus.id_pc, 32'h8);
        check("f2_id_inst", bus.id_inst, 32'h0000_0113);
        check("r4_fault", 32'(bus4.fault), 32'd1);
        check("r4_id_valid", 32'(bus4.id_valid), 32'd0);
        check("r4_rom_addr", 32'(bus4.rom_addr), 32'd4);

        // Redirect beats stall and squashes the EBREAK sitting at pc=0xC
        bus.redirect = 1'b1;
        bus.stall = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        tick();
        check("rd_bubble", 32'(bus.id_valid), 32'd0);
        check("rd_no_halt", 32'(bus.halted), 32'd0);
        check("rd_rom_addr", 32'(bus.rom_addr), 32'd16);

        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        tick();
        check("rd_id_pc", bus.id_pc, 32'h40);
        check("rd_id_inst", bus.id_inst, 32'h0050_0213);
        check("rd_id_valid", 32'(bus.id_valid), 32'd1);
        check("r4_fault_held", 32'(bus4.fault), 32'd1);
        check("r4_rom_addr_held", 32'(bus4.rom_addr), 32'd4);

        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0042;
        tick();
        check("mis_bubble", 32'(bus.id_valid), 32'd0);
`ifdef IF_MISALIGN_CHECK_EN
        check("mis_fault", 32'(bus.fault), 32'd1);
        check("mis_flag", 32'(bus.misalign), 32'd1);
        check("mis_pc_held", 32'(bus.rom_addr), 32'd17);
`else
        check("mis_fault", 32'(bus.fault), 32'd0);
        check("mis_flag", 32'(bus.misalign), 32'd0);
        check("mis_pc_aligned", 32'(bus.rom_addr), 32'd16);
`endif

        bus.redirect = 1'b0;
        tick();
`ifdef IF_MISALIGN_CHECK_EN
        check("mis_sticky", 32'(bus.misalign), 32'd1);
        check("mis_fault_valid", 32'(bus.id_valid), 32'd0);
`else
        check("mis_id_pc", bus.id_pc, 32'h40);
        check("mis_id_valid", 32'(bus.id_valid), 32'd1);
        check("mis_flag_tied", 32'(bus.misalign), 32'd0);
`endif

        rst = 1'b1;
        bus.stall = 1'b1;
        tick();
        check("rst2_fault", 32'(bus.fault), 32'd0);
        check("rst2_misalign", 32'(bus.misalign), 32'd0);
        check("rst2_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst2_id_inst", bus.id_inst, 32'h0000_0013);
        check("rst2_r4_fault", 32'(bus4.fault), 32'd0);

        rst = 1'b0;
        bus.stall = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("eb_id_pc", bus.id_pc, 32'hC);
        check("eb_id_inst", bus.id_inst, 32'h0010_0073);
        check("eb_id_valid", 32'(bus.id_valid), 32'd1);
        check("eb_halted", 32'(bus.halted), 32'd1);

        // Redirect is ignored once halted
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0000;
        tick();
        check("h_id_valid", 32'(bus.id_valid), 32'd0);
        check("h_halted", 32'(bus.halted), 32'd1);
        check("h_rom_addr", 32'(bus.rom_addr), 32'd4);
        tick();
        check("h_rom_addr2", 32'(bus.rom_addr), 32'd4);
        check("h_halted2", 32'(bus.halted), 32'd1);

        bus.redirect = 1'b0;
        rst = 1'b1;
        tick();
        check("rst3_halted", 32'(bus.halted), 32'd0);
        check("rst3_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst3_id_valid", 32'(bus.id_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address fetched first after reset.
REQ-002 SHALL have parameter ROM_WORDS, default 2049, meaning the number of valid instruction-ROM words.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port rom_addr  output  20  meaning the ROM word index, driven as pc[21:2], combinational from pc.
REQ-006 SHALL have port rom_inst  input  32  meaning the ROM data for rom_addr, valid in the same cycle (combinational ROM).
REQ-007 SHALL have port stall  input  1  meaning: hold pc and the IF/ID register this cycle.
REQ-008 SHALL have port redirect  input  1  meaning: load pc from redirect_pc and squash the current fetch.
REQ-009 SHALL have port redirect_pc  input  32  meaning the redirect target byte address.
REQ-010 SHALL have port id_pc  output  32  meaning the registered PC of the instruction in IF/ID.
REQ-011 SHALL have port id_inst  output  32  meaning the registered instruction in IF/ID.
REQ-012 SHALL have port id_valid  output  1  meaning that IF/ID holds a live instruction.
REQ-013 SHALL have port halted  output  1  meaning state==HALT.
REQ-014 SHALL have port fault  output  1  meaning state==FAULT.
REQ-015 SHALL have port misalign  output  1  meaning that the fault cause is a misaligned redirect (sticky until reset).

Function
REQ-016 SHALL implement states RUN, HALT, FAULT; the state register is 2 bits wide.
REQ-017 In RUN, event priority SHALL be: redirect > stall > out-of-range > normal fetch.
REQ-018 Normal fetch (RUN, no redirect/stall, pc[31:2] < ROM_WORDS) SHALL on the edge set id_inst<=rom_inst, id_pc<=pc, id_valid<=1, pc<=pc+4 (32-bit wrap).
REQ-019 Redirect in RUN SHALL set pc<=redirect_pc with bits [1:0] forced to 00 and id_valid<=0 (bubble), regardless of stall.
REQ-020 Stall without redirect SHALL hold pc, id_pc, id_inst and id_valid unchanged.
REQ-021 Out of range (pc[31:2] >= ROM_WORDS, RUN, no redirect/stall) SHALL set id_valid<=0 and state<=FAULT; pc is held.
REQ-022 Capturing rom_inst==32'h0010_0073 (EBREAK) by a normal fetch SHALL latch it with id_valid<=1 and set state<=HALT.
REQ-023 An EBREAK squashed by a simultaneous redirect, or held by stall, SHALL NOT cause HALT.
REQ-024 In HALT or FAULT: pc is held; id_valid<=0 on the next edge unless stall=1 (in that case IF/ID is held); redirect is ignored; only rst exits.
REQ-025 Latency: ROM word to id_inst SHALL take exactly 1 cycle; the redirect target appears on id_pc 2 cycles after redirect is asserted.

Reset
REQ-026 rst SHALL override all inputs and set pc=RESET_PC, state=RUN, id_valid=0, id_pc=0, id_inst=32'h0000_0013 (NOP), misalign=0.
REQ-027 rst asserted mid-stall, mid-redirect or in HALT/FAULT SHALL give the REQ-026 values on the next edge.

Configuration
REQ-028 With macro IF_MISALIGN_CHECK_EN defined, a redirect in RUN with redirect_pc[1:0]!=00 SHALL set state<=FAULT, misalign<=1, id_valid<=0, and leave pc unchanged.
REQ-029 Without IF_MISALIGN_CHECK_EN, redirect_pc[1:0] SHALL be ignored per REQ-019 and misalign SHALL be tied to 0.

Verification
REQ-030 Reset then 3 free-running cycles with ROM[0..2]=13,93,113 (hex) -> id_pc 0,4,8; id_inst 0x13,0x93,0x113; id_valid=1 from cycle 1.
REQ-031 stall=1 for 2 cycles at pc=8 -> id_pc stays 4, rom_addr stays 2; the fetch resumes with id_pc=8.
REQ-032 redirect=1 together with stall=1, redirect_pc=0x40 -> next id_valid=0; the following id_pc=0x40 with id_inst=ROM[16].
REQ-033 ROM[3]=0x00100073 -> id_pc=0xC with id_valid=1, then halted=1 and id_valid=0; redirect to 0x0 is ignored; rst gives pc=0 and halted=0.
REQ-034 ROM_WORDS=4 and fetching to pc=0x10 -> fault=1, id_valid=0, rom_addr held at 4.
REQ-035 With IF_MISALIGN_CHECK_EN, redirect_pc=0x42 -> fault=1 and misalign=1; without the macro, id_pc=0x40 and misalign=0.
